control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port Clock, reset port Reset.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high; sampled on the Clock rising edge.
REQ-004 Run  input  1  start/continue fetch-execute; sampled in IDLE and in T5.
REQ-005 IR  input  32  instruction register contents from the datapath; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-006 MemReady  input  1  memory read complete; used only when SEQ_MEM_WAIT_EN is defined.
REQ-007 PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  output  1 each  datapath bus and latch strobes.
REQ-008 RegOut  output  16  one-hot general-register bus-drive select (bit n = Rn).
REQ-009 RegIn  output  16  one-hot general-register load select.
REQ-010 AluOp  output  5  ALU operation code; equals opcode during T4, else 0.
REQ-011 Busy  output  1  high in states T0 through T5.
REQ-012 Fault  output  1  high in state FAULT.

Function
REQ-013 States: IDLE, T0, T1, T2, T3, T4, T5, FAULT; state SHALL be held in a register updated only on the Clock rising edge.
REQ-014 Outputs SHALL be decoded combinationally from the current state and IR only; every output not listed for a state SHALL be 0.
REQ-015 IDLE: all strobes 0; next = T0 if Run=1, else IDLE.
REQ-016 T0: PCout, MARin, IncPC, Zin = 1; next = T1.
REQ-017 T1: Zlowout, PCin, Read, MDRin = 1; next = T2 (see REQ-027 for the wait variant).
REQ-018 T2: MDRout, IRin = 1; next = T3.
REQ-019 T3: opcode legality checked; legal opcodes ADD 00011, SUB 00100, AND 01001, OR 01010; if legal RegOut[Rb] = 1 and Yin = 1, next = T4; if illegal all strobes 0, next = FAULT.
REQ-020 T4: RegOut[Rc] = 1, AluOp = opcode, Zin = 1; next = T5.
REQ-021 T5: Zlowout = 1, RegIn[Ra] = 1; next = T0 if Run=1, else IDLE.
REQ-022 FAULT: all strobes 0, Fault = 1; remains until Reset.
REQ-023 RegOut and RegIn SHALL have at most one bit set in any cycle; Rb = Rc or Ra = Rb SHALL be legal and decoded normally.
REQ-024 Nominal latency: 6 cycles per instruction, T0 through T5; back-to-back instructions with no IDLE cycle while Run stays 1.
REQ-025 Run deasserted during T0 through T4 SHALL NOT abort the instruction; it takes effect at T5.

Reset
REQ-026 Reset=1 at a rising edge SHALL force IDLE from any state, including mid-instruction and FAULT; in the following cycle all outputs SHALL be 0, Busy = 0 and Fault = 0; Reset has priority over Run.

Configuration
REQ-027 Macro SEQ_MEM_WAIT_EN: when defined, T1 holds, with its strobes asserted, until MemReady = 1 at a rising edge, then goes to T2; when undefined, T1 lasts exactly one cycle and MemReady is ignored.

Verification
REQ-028 Reset, Run=1, IR=32'h4A920000 (and R5,R2,R4) loaded by T3 -> T3 RegOut=16'h0004 and Yin; T4 RegOut=16'h0010, AluOp=5'b01001, Zin; T5 RegIn=16'h0020, Zlowout; 6 cycles total.
REQ-029 Run held 1 across two instructions (ADD then SUB) -> T5 followed directly by T0; AluOp 5'b00011 then 5'b00100; no IDLE cycle between them.
REQ-030 IR opcode 5'b11111 at T3 -> no strobes in T3; FAULT next cycle with Fault=1; Fault stays 1 with Run toggling; Reset -> IDLE, Fault=0.
REQ-031 Reset asserted during T4 -> next cycle IDLE with all outputs 0; RegIn never nonzero for that instruction.
REQ-032 SEQ_MEM_WAIT_EN defined, MemReady low for 3 cycles in T1 -> T1 strobes held 4 cycles, then T2; undefined -> T1 lasts 1 cycle regardless of MemReady.
REQ-033 Run dropped during T2 -> instruction completes through T5, then IDLE; Busy=0.

Source files
------------

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control FSM driving the bus and latch strobes of a simple register datapath.
// Build option `SEQ_MEM_WAIT_EN: hold T1 (memory read) until MemReady is seen high.
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [31:0] IR,
    input  logic        MemReady,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] RegOut,
    output logic [15:0] RegIn,
    output logic [4:0]  AluOp,
    output logic        Busy,
    output logic        Fault
);

    // state | meaning
    // IDLE  | waiting for Run, no strobes
    // T0    | PC to MAR, PC+1 into Z
    // T1    | Z to PC, memory read into MDR
    // T2    | MDR to IR
    // T3    | opcode check, Rb into Y
    // T4    | Rc with Y through the ALU into Z
    // T5    | Z to Ra, Run decides next instruction or IDLE
    // FAULT | illegal opcode seen, held until Reset
    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_FAULT
    } state_t;

    state_t state, state_next;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       op_legal;
    logic       mem_done;

    assign opcode   = IR[31:27];
    assign ra       = IR[26:23];
    assign rb       = IR[22:19];
    assign rc       = IR[18:15];
    assign op_legal = (opcode == 5'b00011) || (opcode == 5'b00100) ||
                      (opcode == 5'b01001) || (opcode == 5'b01010);

`ifdef SEQ_MEM_WAIT_EN
    assign mem_done = MemReady;
    logic unused_ir_low;
    assign unused_ir_low = ^IR[14:0];
`else
    assign mem_done = 1'b1;
    logic unused_inputs;
    assign unused_inputs = ^{IR[14:0], MemReady};
`endif

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = Run ? S_T0 : S_IDLE;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = mem_done ? S_T2 : S_T1;
            S_T2:    state_next = S_T3;
            S_T3:    state_next = op_legal ? S_T4 : S_FAULT;
            S_T4:    state_next = S_T5;
            S_T5:    state_next = Run ? S_T0 : S_IDLE;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        RegOut  = 16'h0000;
        RegIn   = 16'h0000;
        AluOp   = 5'b00000;
        Busy    = 1'b0;
        Fault   = 1'b0;
        case (state)
            S_T0: begin
                Busy  = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Busy    = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                Busy   = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Busy = 1'b1;
                // an illegal opcode must not disturb Y or the register bus
                if (op_legal) begin
                    RegOut = 16'h0001 << rb;
                    Yin    = 1'b1;
                end
            end
            S_T4: begin
                Busy   = 1'b1;
                RegOut = 16'h0001 << rc;
                AluOp  = opcode;
                Zin    = 1'b1;
            end
            S_T5: begin
                Busy    = 1'b1;
                Zlowout = 1'b1;
                RegIn   = 16'h0001 << ra;
            end
            S_FAULT: Fault = 1'b1;
            default: ;
        endcase
    end

endmodule
